// File: rtl/decoder_arith_pkg.sv
// Shared widths, saturation bounds and divider FSM states for the decoder
// arithmetic blocks (divider writeback and multiplier writeback).
package decoder_arith_pkg;

  localparam int DIVIDEND_WIDTH = 24;
  localparam int DIVISOR_WIDTH  = 8;
  localparam int QUOTIENT_WIDTH = 16;
  localparam int REM_WIDTH      = DIVISOR_WIDTH + 1;

  localparam logic [QUOTIENT_WIDTH-1:0] SAT_MAX = {1'b0, {(QUOTIENT_WIDTH-1){1'b1}}};
  localparam logic [QUOTIENT_WIDTH-1:0] SAT_MIN = {1'b1, {(QUOTIENT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

endpackage

// File: rtl/decoder_sat_narrow.sv
// Combinational signed narrowing IN_W -> OUT_W, clamping to the signed range
// of OUT_W and flagging ovf when the value did not fit.
module decoder_sat_narrow
  import decoder_arith_pkg::*;
#(
  parameter int IN_W  = DIVIDEND_WIDTH + 1,
  parameter int OUT_W = QUOTIENT_WIDTH
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             ovf
);

  logic [IN_W-OUT_W:0] top_bits;

  // The value fits only if every bit above the output sign bit copies it.
  always_comb begin
    top_bits = din[IN_W-1:OUT_W-1];
    ovf      = !((&top_bits) || !(|top_bits));
    dout     = din[OUT_W-1:0];
    if (ovf) begin
      dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/decoder_div_24s_8ns_16_seq.sv
// Sequential restoring divider: signed dividend / unsigned divisor, one quotient
// bit per cycle, saturated signed quotient and exact remainder, valid/ready both sides.
module decoder_div_24s_8ns_16_seq #(
  parameter int DIVIDEND_WIDTH = decoder_arith_pkg::DIVIDEND_WIDTH,
  parameter int DIVISOR_WIDTH  = decoder_arith_pkg::DIVISOR_WIDTH,
  parameter int QUOTIENT_WIDTH = decoder_arith_pkg::QUOTIENT_WIDTH,
  parameter int REM_WIDTH      = DIVISOR_WIDTH + 1
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [QUOTIENT_WIDTH-1:0] quot,
  output logic [REM_WIDTH-1:0]      rem,
  output logic                      ovf,
  output logic                      dz
);

  import decoder_arith_pkg::*;

  localparam int CNT_W = $clog2(DIVIDEND_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_WIDTH - 1);
  localparam logic [QUOTIENT_WIDTH-1:0] Q_MAX = {1'b0, {(QUOTIENT_WIDTH-1){1'b1}}};
  localparam logic [QUOTIENT_WIDTH-1:0] Q_MIN = {1'b1, {(QUOTIENT_WIDTH-1){1'b0}}};

  div_state_e state_q, state_d;
  logic [DIVIDEND_WIDTH-1:0] dvd_q, dvd_d;
  logic [DIVIDEND_WIDTH-1:0] q_q, q_d;
  logic [REM_WIDTH-1:0]      prem_q, prem_d;
  logic [DIVISOR_WIDTH-1:0]  dvs_q, dvs_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      neg_q, neg_d;
  logic                      out_valid_q, out_valid_d;
  logic [QUOTIENT_WIDTH-1:0] quot_q, quot_d;
  logic [REM_WIDTH-1:0]      rem_q, rem_d;
  logic                      ovf_q, ovf_d;
  logic                      dz_q, dz_d;

  logic [REM_WIDTH-1:0]      trial;
  logic [REM_WIDTH:0]        sub;
  logic [DIVIDEND_WIDTH:0]   q_signed;
  logic [QUOTIENT_WIDTH-1:0] q_sat;
  logic                      q_ovf;

  // The magnitude of the most-negative dividend is 2^(W-1), which still fits
  // W unsigned bits, so the shift register only needs the dividend width.
  assign trial    = {prem_q[REM_WIDTH-2:0], dvd_q[DIVIDEND_WIDTH-1]};
  assign sub      = {1'b0, trial} - {2'b00, dvs_q};
  assign q_signed = neg_q ? -{1'b0, q_q} : {1'b0, q_q};

  decoder_sat_narrow #(
    .IN_W  (DIVIDEND_WIDTH + 1),
    .OUT_W (QUOTIENT_WIDTH)
  ) u_sat (
    .din  (q_signed),
    .dout (q_sat),
    .ovf  (q_ovf)
  );

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    q_d         = q_q;
    prem_d      = prem_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    out_valid_d = out_valid_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    ovf_d       = ovf_q;
    dz_d        = dz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          neg_d  = din0[DIVIDEND_WIDTH-1];
          dvd_d  = din0[DIVIDEND_WIDTH-1] ? -din0 : din0;
          dvs_d  = din1;
          prem_d = '0;
          q_d    = '0;
          cnt_d  = CNT_LAST;
          if (din1 == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            quot_d      = din0[DIVIDEND_WIDTH-1] ? Q_MIN : Q_MAX;
            rem_d       = '0;
            ovf_d       = 1'b0;
            dz_d        = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // A borrow out of the trial subtraction means the divisor did not fit.
        dvd_d  = dvd_q << 1;
        prem_d = sub[REM_WIDTH] ? trial : sub[REM_WIDTH-1:0];
        q_d    = {q_q[DIVIDEND_WIDTH-2:0], ~sub[REM_WIDTH]};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        quot_d      = q_sat;
        ovf_d       = q_ovf;
        rem_d       = neg_q ? -prem_q : prem_q;
        dz_d        = 1'b0;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      q_q         <= '0;
      prem_q      <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      q_q         <= q_d;
      prem_q      <= prem_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      ovf_q       <= ovf_d;
      dz_q        <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_decoder_div_24s_8ns_16_seq.sv
// Randomised and directed bench for the sequential divider against an
// integer-arithmetic reference model.
module tb_decoder_div_24s_8ns_16_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] din0 = '0;
  logic [7:0]  din1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quot;
  logic [8:0]  rem;
  logic        ovf;
  logic        dz;

  int n_cmp = 0;
  int n_err = 0;
  int e_q, e_r, e_ovf, e_dz, e_lat;

  decoder_div_24s_8ns_16_seq dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .ovf       (ovf),
    .dz        (dz)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: truncating integer division, remainder takes the dividend's sign.
  function automatic void model(input int a, input int b);
    int t;
    if (b == 0) begin
      e_q = (a >= 0) ? 32767 : -32768;
      e_r = 0; e_ovf = 0; e_dz = 1; e_lat = 1;
    end else begin
      t = a / b;
      e_r = a % b; e_dz = 0; e_lat = 26; e_ovf = 0; e_q = t;
      if (t > 32767) begin e_q = 32767; e_ovf = 1; end
      if (t < -32768) begin e_q = -32768; e_ovf = 1; end
    end
  endfunction

  task automatic issue(input int a, input int b);
    model(a, b);
    @(negedge ap_clk);
    chk("in_ready_before_accept", int'(in_ready), 1);
    din0 = a[23:0];
    din1 = b[7:0];
    in_valid = 1'b1;
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    din0 = 24'($urandom);
    din1 = 8'($urandom);
  endtask

  task automatic await_result(input string tag);
    int lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge ap_clk);
      #1;
      lat++;
    end
    chk({tag, ".latency"}, lat, e_lat);
    chk({tag, ".quot"}, int'($signed(quot)), e_q);
    chk({tag, ".rem"}, int'($signed(rem)), e_r);
    chk({tag, ".ovf"}, int'(ovf), e_ovf);
    chk({tag, ".dz"}, int'(dz), e_dz);
  endtask

  task automatic retire(input string tag, input int delay);
    repeat (delay) @(posedge ap_clk);
    @(negedge ap_clk);
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".out_valid_drop"}, int'(out_valid), 0);
    chk({tag, ".in_ready_back"}, int'(in_ready), 1);
  endtask

  int da[6] = '{1000, -1000, 8388607, -8388608, -5, 5};
  int db[6] = '{10, 7, 1, 255, 0, 0};

  initial begin
    #12;
    chk("rst.in_ready", int'(in_ready), 1);
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.quot", int'(quot), 0);
    chk("rst.rem", int'(rem), 0);
    chk("rst.ovf", int'(ovf), 0);
    chk("rst.dz", int'(dz), 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      issue(da[i], db[i]);
      await_result($sformatf("dir%0d", i));
      retire($sformatf("dir%0d", i), 0);
    end

    // Backpressure: result held, new operands ignored until handshake.
    issue(1000, 10);
    await_result("hold");
    for (int c = 0; c < 10; c++) begin
      @(negedge ap_clk);
      if (c == 4) begin
        din0 = 24'd77;
        din1 = 8'd3;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge ap_clk);
      #1;
      chk("hold.out_valid", int'(out_valid), 1);
      chk("hold.in_ready", int'(in_ready), 0);
      chk("hold.quot", int'($signed(quot)), e_q);
      chk("hold.rem", int'($signed(rem)), e_r);
    end
    in_valid = 1'b0;
    retire("hold", 0);
    issue(-1000, 7);
    await_result("after_hold");
    retire("after_hold", 0);

    // Asynchronous reset in the middle of CALC.
    issue(12345, 17);
    repeat (11) @(posedge ap_clk);
    #3;
    ap_rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", int'(out_valid), 0);
    chk("midrst.in_ready", int'(in_ready), 1);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    issue(100, 3);
    await_result("post_rst");
    retire("post_rst", 0);

    for (int k = 0; k < 40; k++) begin
      logic [23:0] r24;
      int a, b;
      r24 = 24'($urandom);
      a = int'($signed(r24));
      if ($urandom_range(5) == 0) a = a / int'($urandom_range(4000, 1));
      b = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(255, 1));
      issue(a, b);
      await_result($sformatf("rnd%0d", k));
      retire($sformatf("rnd%0d", k), int'($urandom_range(3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/decoder_div_24s_8ns_16_seq.md
Name: decoder_div_24s_8ns_16_seq

Overview:
- Multi-cycle sequential divider: signed dividend by unsigned divisor, producing a signed, saturated quotient and a signed remainder.
- Inverse of the decoder's signed × unsigned product path. It rescales 24-bit accumulator results back into the 16-bit activation domain when the scale factor is runtime-variable.
- Sits between the decoder MAC stage and the activation writeback. Uses a valid/ready handshake on both sides.

Parameters:
- DIVIDEND_WIDTH, 24, signed dividend width.
- DIVISOR_WIDTH, 8, unsigned divisor width.
- QUOTIENT_WIDTH, 16, signed quotient output width; must be ≤ DIVIDEND_WIDTH.
- REM_WIDTH, DIVISOR_WIDTH+1, signed remainder output width.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- din0  in  DIVIDEND_WIDTH  signed dividend.
- din1  in  DIVISOR_WIDTH  unsigned divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- quot  out  QUOTIENT_WIDTH  signed quotient, truncated toward zero, saturated.
- rem  out  REM_WIDTH  signed remainder; sign follows the dividend.
- ovf  out  1  quotient saturated because it is out of range.
- dz  out  1  divisor was zero.

Behaviour:
- Reset (ap_rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, quot=0, rem=0, ovf=0, dz=0. Reset mid-operation aborts the operation; no result is produced.
- States and transitions:
  - IDLE: in_ready=1. On in_valid, capture the dividend sign, |din0| in DIVIDEND_WIDTH+1 bits (so the most-negative value is handled), and din1.
  - From IDLE: if din1==0 go to DONE with dz=1. Otherwise go to CALC with the iteration counter = DIVIDEND_WIDTH-1.
  - CALC: restoring division, one quotient bit per cycle, MSB first.
    - Partial remainder is DIVISOR_WIDTH+1 bits: shift in the next dividend bit, subtract the divisor, keep the result if non-negative, and set the quotient bit.
    - When the counter reaches 0, go to FIX.
  - FIX: apply signs. quot = -q if the dividend is negative, else q. rem = -r if the dividend is negative, else r.
    - Saturate quot: if the true result is > 2^(QW-1)-1, output 2^(QW-1)-1 with ovf=1. If the true result is < -2^(QW-1), output -2^(QW-1) with ovf=1.
    - rem is always the exact remainder.
    - Go to DONE.
  - DONE: out_valid=1. quot, rem, ovf and dz are held stable while out_valid=1 and out_ready=0. When out_ready=1, return to IDLE on the next edge, with out_valid=0.
- Divide-by-zero: quot = 2^(QW-1)-1 if the dividend is ≥ 0, else -2^(QW-1). rem=0, dz=1, ovf=0.
- Latency from the accepting edge to out_valid high:
  - Normal operation: DIVIDEND_WIDTH+2 edges (26 by default).
  - Divide-by-zero: 1 edge.
- Throughput: one operation in flight at a time. in_ready=0 in CALC, FIX and DONE.
  - The next operand pair can be accepted no earlier than the cycle after the output handshake.
- in_valid while in_ready=0 is ignored; din0 and din1 are don't-care there.
- All outputs are registered. There is no combinational path from inputs to outputs other than in_ready, which is decoded from state.

Decomposition:
- Shared package decoder_arith_pkg:
  - state enum {IDLE, CALC, FIX, DONE};
  - width constants;
  - SAT_MAX and SAT_MIN localparams derived from QUOTIENT_WIDTH.
- One sub-module, decoder_sat_narrow: combinational signed narrowing from DIVIDEND_WIDTH+1 to QUOTIENT_WIDTH with an ovf flag. It is reusable by the multiplier writeback path.

Test Plan:
- din0=1000, din1=10 → quot=100, rem=0, ovf=0, dz=0; out_valid exactly 26 edges after acceptance.
- din0=-1000, din1=7 → quot=-142, rem=-6, ovf=0.
- din0=8388607, din1=1 → quot=32767, ovf=1. Then din0=-8388608, din1=255 → quot=-32768, ovf=1, rem=-128.
- din0=-5, din1=0 → quot=-32768, dz=1, rem=0, out_valid 1 edge after acceptance. din0=5, din1=0 → quot=32767, dz=1.
- Hold out_ready=0 for 10 cycles after out_valid → outputs stable and in_ready=0 throughout; a pulsed in_valid is ignored. Raise out_ready → IDLE next edge, and a new operation is accepted.
- Assert ap_rst_n low asynchronously in the 12th CALC cycle → out_valid=0 and in_ready=1 immediately. Release reset, run 100/3 → quot=33, rem=1, with no stale result.
